// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC: a quadrant pre-rotation stage followed by STAGES micro-rotations.
// Each sample selects rotation (drive z to 0) or vectoring (drive y to 0); x/y keep the CORDIC gain.

module cordic_pipe #(
   parameter int WIDTH   = 16,
   parameter int ANGLE_W = 16,
   parameter int STAGES  = 14
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      in_valid,
   input  logic                      mode_in,
   input  logic signed [WIDTH-1:0]   x_in,
   input  logic signed [WIDTH-1:0]   y_in,
   input  logic signed [ANGLE_W-1:0] z_in,
   output logic                      out_valid,
   output logic signed [WIDTH-1:0]   x_out,
   output logic signed [WIDTH-1:0]   y_out,
   output logic signed [ANGLE_W-1:0] z_out,
   output logic                      mode_out
);

   localparam logic signed [ANGLE_W-1:0] HALF_PI = {2'b01, {(ANGLE_W-2){1'b0}}};

   // atan(2^-i) scaled so that 2^31 represents pi
   function automatic logic [31:0] atanTable(input int i);
      logic [31:0] t;
      case (i)
         0:       t = 32'h20000000;
         1:       t = 32'h12E4051E;
         2:       t = 32'h09FB385B;
         3:       t = 32'h051111D4;
         4:       t = 32'h028B0D43;
         5:       t = 32'h0145D7E1;
         6:       t = 32'h00A2F61E;
         7:       t = 32'h00517C55;
         8:       t = 32'h0028BE53;
         9:       t = 32'h00145F2F;
         10:      t = 32'h000A2F98;
         11:      t = 32'h000517CC;
         12:      t = 32'h00028BE6;
         13:      t = 32'h000145F3;
         14:      t = 32'h0000A2FA;
         15:      t = 32'h0000517D;
         16:      t = 32'h000028BE;
         17:      t = 32'h0000145F;
         18:      t = 32'h00000A30;
         19:      t = 32'h00000518;
         20:      t = 32'h0000028C;
         21:      t = 32'h00000146;
         22:      t = 32'h000000A3;
         23:      t = 32'h00000051;
         default: t = 32'h00000000;
      endcase
      return t;
   endfunction

   // Round-to-nearest narrowing; the extra LSB keeps the shift legal when ANGLE_W is 32
   function automatic logic signed [ANGLE_W-1:0] atanRounded(input int i);
      logic [32:0] sum;
      sum = {atanTable(i), 1'b0} + (33'd1 << (32 - ANGLE_W));
      return $signed(ANGLE_W'(sum >> (33 - ANGLE_W)));
   endfunction

   logic signed [WIDTH-1:0]   xs [0:STAGES];
   logic signed [WIDTH-1:0]   ys [0:STAGES];
   logic signed [ANGLE_W-1:0] zs [0:STAGES];
   logic                      vs [0:STAGES];
   logic                      ms [0:STAGES];

   logic signed [WIDTH-1:0]   preX, preY;
   logic signed [ANGLE_W-1:0] preZ;
   logic signed [WIDTH-1:0]   pX, pY;
   logic signed [ANGLE_W-1:0] pZ;
   logic                      pV, pM;

   // Fold the vector into the right half-plane so the micro-rotations can converge
   always_comb begin
      preX = x_in;
      preY = y_in;
      preZ = z_in;
      if (!mode_in) begin
         if (z_in > HALF_PI) begin
            preX = -y_in;
            preY = x_in;
            preZ = z_in - HALF_PI;
         end else if (z_in < -HALF_PI) begin
            preX = y_in;
            preY = -x_in;
            preZ = z_in + HALF_PI;
         end
      end else if (x_in[WIDTH-1]) begin
         if (!y_in[WIDTH-1]) begin
            preX = y_in;
            preY = -x_in;
            preZ = z_in + HALF_PI;
         end else begin
            preX = -y_in;
            preY = x_in;
            preZ = z_in - HALF_PI;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pX <= '0;
         pY <= '0;
         pZ <= '0;
         pV <= 1'b0;
         pM <= 1'b0;
      end else if (en) begin
         pX <= preX;
         pY <= preY;
         pZ <= preZ;
         pV <= in_valid;
         pM <= mode_in;
      end
   end

   assign xs[0] = pX;
   assign ys[0] = pY;
   assign zs[0] = pZ;
   assign vs[0] = pV;
   assign ms[0] = pM;

   for (genvar i = 0; i < STAGES; i++) begin : gStage
      localparam logic signed [ANGLE_W-1:0] ATAN = atanRounded(i);

      logic                      dirPos;
      logic signed [WIDTH-1:0]   xR, yR;
      logic signed [ANGLE_W-1:0] zR;
      logic                      vR, mR;

      assign dirPos = ms[i] ? ys[i][WIDTH-1] : !zs[i][ANGLE_W-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            xR <= '0;
            yR <= '0;
            zR <= '0;
            vR <= 1'b0;
            mR <= 1'b0;
         end else if (en) begin
            xR <= dirPos ? xs[i] - (ys[i] >>> i) : xs[i] + (ys[i] >>> i);
            yR <= dirPos ? ys[i] + (xs[i] >>> i) : ys[i] - (xs[i] >>> i);
            zR <= dirPos ? zs[i] - ATAN : zs[i] + ATAN;
            vR <= vs[i];
            mR <= ms[i];
         end
      end

      assign xs[i+1] = xR;
      assign ys[i+1] = yR;
      assign zs[i+1] = zR;
      assign vs[i+1] = vR;
      assign ms[i+1] = mR;
   end

   assign out_valid = vs[STAGES];
   assign x_out     = xs[STAGES];
   assign y_out     = ys[STAGES];
   assign z_out     = zs[STAGES];
   assign mode_out  = ms[STAGES];

endmodule

// File: doc/cordic_pipe.md
CORDIC_PIPE -- requirements
Module: cordic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the signed two's-complement width of x and y.
REQ-002 SHALL have parameter ANGLE_W, default 16, giving the signed binary-angle width; +2^(ANGLE_W-1) represents +pi.
REQ-003 SHALL have parameter STAGES, default 14, legal range 1..24, giving the number of micro-rotation stages.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1 bit, the pipeline advance enable; when low, the whole pipeline holds.
REQ-007 SHALL have port in_valid, input, 1 bit, which qualifies x_in, y_in, z_in and mode_in.
REQ-008 SHALL have port mode_in, input, 1 bit: 0 selects rotation, 1 selects vectoring; it travels with its sample.
REQ-009 SHALL have ports x_in and y_in, inputs, WIDTH bits, signed.
REQ-010 SHALL have port z_in, input, ANGLE_W bits, signed binary angle.
REQ-011 SHALL have port out_valid, input-aligned, output, 1 bit, which qualifies the outputs.
REQ-012 SHALL have ports x_out and y_out, outputs, WIDTH bits, and z_out, output, ANGLE_W bits, all registered.
REQ-013 SHALL have port mode_out, output, 1 bit, carrying the mode of the sample on the outputs.

Function
REQ-014 SHALL be a fully pipelined datapath: stage P (quadrant pre-rotation) followed by STAGES micro-rotation stages 0..STAGES-1, each registered.
REQ-015 SHALL have a latency of exactly STAGES+1 enabled clk edges from in_valid sampled high to the matching out_valid high; throughput is one sample per enabled edge.
REQ-016 SHALL propagate valid and mode in per-stage registers alongside the data; bubbles (in_valid=0) SHALL propagate as out_valid=0.
REQ-017 Stage P, rotation mode: if z > +pi/2, x'=-y, y'=x, z'=z-pi/2; if z < -pi/2, x'=y, y'=-x, z'=z+pi/2; otherwise pass through.
REQ-018 Stage P, vectoring mode: if x<0 and y>=0, x'=y, y'=-x, z'=z+pi/2; if x<0 and y<0, x'=-y, y'=x, z'=z-pi/2; otherwise pass through.
REQ-019 Stage i, direction d=+1 when (rotation and z>=0) or (vectoring and y<0); otherwise d=-1.
REQ-020 Stage i, d=+1: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-atan_i; d=-1: x'=x+(y>>>i), y'=y-(x>>>i), z'=z+atan_i.
REQ-021 Shifts SHALL be arithmetic; all add/subtract SHALL wrap modulo 2^WIDTH (x,y) or 2^ANGLE_W (z), with no saturation.
REQ-022 atan_i SHALL be a constant equal to round(atan(2^-i)*2^(ANGLE_W-1)/pi), derived from a 32-bit internal table truncated to ANGLE_W bits by rounding.
REQ-023 Outputs SHALL carry the uncompensated CORDIC gain K≈1.6468 on x and y; the caller pre-scales.
REQ-024 When en=0, every register including valid and mode SHALL hold its value; in_valid is ignored.
REQ-025 Mode MAY differ sample-to-sample; adjacent samples of different mode SHALL NOT interfere.
REQ-026 When not valid, output data values are don't-care but SHALL be deterministic (the bubble data propagates).

Reset
REQ-027 rst_n low SHALL immediately clear all stage valid bits, out_valid, mode_out, x_out, y_out and z_out to 0, independent of clk and en.
REQ-028 Samples in flight at reset assertion SHALL be discarded; the first out_valid after release SHALL come from a sample presented after release.
REQ-029 After rst_n rises, the first enabled edge SHALL accept input normally.

Verification
REQ-030 Rotation, defaults: x_in=9949, y_in=0, z_in=0x2000 (pi/4) -> after 15 edges, out_valid=1, x_out≈y_out≈11585 within ±4 LSB, z_out within ±4 of 0.
REQ-031 Pre-rotation: x_in=9949, y_in=0, z_in=0x6000 (3pi/4) -> x_out≈-11585, y_out≈+11585 within ±4 LSB.
REQ-032 Vectoring: x_in=-8192, y_in=8192 -> z_out≈0x6000 within ±4 LSB, x_out≈19079 within ±6 LSB, y_out within ±4 of 0.
REQ-033 Streaming: alternate rotation and vectoring samples for 64 consecutive cycles with random in_valid -> outputs match the reference model sample-for-sample, each exactly 15 enabled edges after its input, with mode_out correct.
REQ-034 Stall: deassert en for 5 cycles mid-stream -> outputs frozen during the stall, no sample lost or duplicated, and latency counted in enabled edges is unchanged.
REQ-035 Reset mid-operation: pulse rst_n low asynchronously between clk edges with 10 samples in flight -> outputs go 0 at once, and no out_valid appears until 15 enabled edges after a new post-reset input.
